ryu_action_ctrl: RTL and testbench

RYU_ACTION_CTRL -- requirements
Module: ryu_action_ctrl

---
 rtl/ryu_action_ctrl.sv | 96 +++++++++
 tb/tb_ryu_action_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ryu_action_ctrl.sv
// ryu_action_ctrl: frame-stepped move/jump/punch controller for the Ryu sprite
module ryu_action_ctrl #(
  parameter int X_INIT       = 100,
  parameter int GROUND_Y     = 300,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 560,
  parameter int WALK_STEP    = 2,
  parameter int JUMP_V0      = 12,
  parameter int GRAVITY      = 1,
  parameter int PUNCH_FRAMES = 8
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_punch,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic [2:0] sprite,
  output logic       busy
);
  typedef enum logic [2:0] {STAND, WALK_L, WALK_R, CROUCH, PUNCH, JUMP} state_t;
  state_t state, state_nxt, free_state;
  logic signed [5:0] vy, vy_nxt, j_vy;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] drift, drift_nxt, j_dr, mv;
  logic armed, is_free, eval, entering_jump, jumping, land;
  logic [9:0] x_left, x_right, x_nxt, y_nxt, j_y;
  logic [2:0] sprite_nxt;
  logic signed [10:0] xl, xr, yd;
  assign xl = $signed({1'b0, RyuX}) - $signed(11'(WALK_STEP));
  assign xr = $signed({1'b0, RyuX}) + $signed(11'(WALK_STEP));
  assign x_left  = xl < $signed(11'(X_MIN)) ? 10'(X_MIN) : xl[9:0];
  assign x_right = xr > $signed(11'(X_MAX)) ? 10'(X_MAX) : xr[9:0];
  // Punch exit re-evaluates free transitions, but never re-enters punch itself
  always_comb begin
    is_free = state == STAND || state == WALK_L || state == WALK_R || state == CROUCH;
    eval = is_free || (state == PUNCH && cnt == 4'd0);
    free_state = (armed && is_free && key_punch) ? PUNCH :
                 key_up ? JUMP :
                 key_down ? CROUCH :
                 (key_left ^ key_right) ? (key_left ? WALK_L : WALK_R) : STAND;
    entering_jump = eval && free_state == JUMP;
    jumping = entering_jump || state == JUMP;
    j_y  = entering_jump ? 10'(GROUND_Y) : RyuY;
    j_vy = entering_jump ? 6'(JUMP_V0) : vy;
    j_dr = entering_jump ? {key_left & ~key_right, key_right & ~key_left} : drift;
    yd = $signed({1'b0, j_y}) - $signed({{5{j_vy[5]}}, j_vy});
    land = state == JUMP && yd >= $signed(11'(GROUND_Y));
    state_nxt = eval ? free_state : state == JUMP ? (land ? STAND : JUMP) : PUNCH;
  end
  // Entry tick already performs the first airborne step
  always_comb begin
    mv = jumping ? j_dr : {state_nxt == WALK_L, state_nxt == WALK_R};
    x_nxt = mv[1] ? x_left : mv[0] ? x_right : RyuX;
    y_nxt = (jumping && !land) ? yd[9:0] : 10'(GROUND_Y);
    vy_nxt = jumping && !land ? j_vy - 6'(GRAVITY) : 6'sd0;
    drift_nxt = jumping && !land ? j_dr : 2'b00;
    cnt_nxt = (eval && free_state == PUNCH) ? 4'(PUNCH_FRAMES - 1) :
              (state == PUNCH && cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
  end
  always_comb begin
    sprite_nxt = state_nxt == PUNCH  ? 3'd1 :
                 state_nxt == JUMP   ? 3'd2 :
                 state_nxt == CROUCH ? 3'd3 :
                 state_nxt == WALK_L ? 3'd4 :
                 state_nxt == WALK_R ? 3'd5 : 3'd0;
    busy = state == PUNCH || state == JUMP;
  end
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state  <= STAND;
      RyuX   <= 10'(X_INIT);
      RyuY   <= 10'(GROUND_Y);
      sprite <= 3'd0;
      vy     <= 6'sd0;
      cnt    <= 4'd0;
      drift  <= 2'b00;
    end else if (frame_tick) begin
      state  <= state_nxt;
      RyuX   <= x_nxt;
      RyuY   <= y_nxt;
      sprite <= sprite_nxt;
      vy     <= vy_nxt;
      cnt    <= cnt_nxt;
      drift  <= drift_nxt;
    end
  end
  always_ff @(posedge vga_clk) begin
    if (Reset || !key_punch) armed <= 1'b1;
    else if (frame_tick && eval && free_state == PUNCH) armed <= 1'b0;
  end
endmodule

// File: tb/tb_ryu_action_ctrl.sv
// tb_ryu_action_ctrl: directed checks of walking, clamping, jump arc, punch and reset
module tb_ryu_action_ctrl;
  logic vga_clk = 0, Reset = 0, frame_tick = 0;
  logic key_left = 0, key_right = 0, key_up = 0, key_down = 0, key_punch = 0;
  logic [9:0] RyuX, RyuY;
  logic [2:0] sprite;
  logic busy;
  int errors = 0, checks = 0;

  ryu_action_ctrl dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_punch(key_punch),
    .RyuX(RyuX), .RyuY(RyuY), .sprite(sprite), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge vga_clk) frame_tick = 1;
      @(negedge vga_clk) frame_tick = 0;
    end
  endtask

  task automatic keys(input logic l, r, u, d, p);
    key_left = l; key_right = r; key_up = u; key_down = d; key_punch = p;
  endtask

  task automatic test_reset;
    @(negedge vga_clk) Reset = 1;
    @(negedge vga_clk) Reset = 0;
    checks += 4;
    if (RyuX !== 10'd100) begin errors++; $display("FAIL reset_x got %0d want 100", RyuX); end
    if (RyuY !== 10'd300) begin errors++; $display("FAIL reset_y got %0d want 300", RyuY); end
    if (sprite !== 3'd0) begin errors++; $display("FAIL reset_sprite got %0d want 0", sprite); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
  endtask

  task automatic test_walk;
    keys(0, 1, 0, 0, 0);
    tick(5);
    checks += 3;
    if (RyuX !== 10'd110) begin errors++; $display("FAIL walk_x got %0d want 110", RyuX); end
    if (RyuY !== 10'd300) begin errors++; $display("FAIL walk_y got %0d want 300", RyuY); end
    if (sprite !== 3'd5) begin errors++; $display("FAIL walk_sprite got %0d want 5", sprite); end
    repeat (4) @(negedge vga_clk);
    checks++;
    if (RyuX !== 10'd110) begin errors++; $display("FAIL no_tick_hold got %0d want 110", RyuX); end
    keys(0, 0, 0, 0, 0);
    tick(1);
    checks += 2;
    if (sprite !== 3'd0) begin errors++; $display("FAIL release_sprite got %0d want 0", sprite); end
    if (RyuX !== 10'd110) begin errors++; $display("FAIL release_x got %0d want 110", RyuX); end
    keys(0, 0, 0, 1, 0);
    tick(1);
    checks += 2;
    if (sprite !== 3'd3) begin errors++; $display("FAIL crouch_sprite got %0d want 3", sprite); end
    if (RyuX !== 10'd110) begin errors++; $display("FAIL crouch_x got %0d want 110", RyuX); end
    keys(0, 0, 0, 0, 0);
    tick(1);
  endtask

  task automatic test_priority;
    keys(1, 0, 1, 0, 1);
    tick(1);
    checks += 3;
    if (sprite !== 3'd1) begin errors++; $display("FAIL prio_sprite got %0d want 1", sprite); end
    if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy got %0b want 1", busy); end
    if (RyuX !== 10'd110) begin errors++; $display("FAIL prio_x got %0d want 110", RyuX); end
    keys(0, 0, 0, 0, 0);
    tick(8);
    checks++;
    if (sprite !== 3'd0) begin errors++; $display("FAIL prio_end got %0d want 0", sprite); end
    keys(1, 1, 0, 0, 0);
    tick(2);
    checks += 2;
    if (sprite !== 3'd0) begin errors++; $display("FAIL lr_sprite got %0d want 0", sprite); end
    if (RyuX !== 10'd110) begin errors++; $display("FAIL lr_x got %0d want 110", RyuX); end
    keys(0, 0, 0, 0, 0);
  endtask

  task automatic test_clamp;
    keys(0, 1, 0, 0, 0);
    tick(224);
    checks++;
    if (RyuX !== 10'd558) begin errors++; $display("FAIL reach_558 got %0d want 558", RyuX); end
    tick(3);
    checks++;
    if (RyuX !== 10'd560) begin errors++; $display("FAIL clamp_right got %0d want 560", RyuX); end
    keys(1, 0, 0, 0, 0);
    tick(279);
    checks++;
    if (RyuX !== 10'd2) begin errors++; $display("FAIL reach_2 got %0d want 2", RyuX); end
    tick(3);
    checks += 2;
    if (RyuX !== 10'd0) begin errors++; $display("FAIL clamp_left got %0d want 0", RyuX); end
    if (sprite !== 3'd4) begin errors++; $display("FAIL left_sprite got %0d want 4", sprite); end
    keys(0, 0, 0, 0, 0);
    tick(1);
  endtask

  task automatic test_jump;
    keys(0, 0, 1, 0, 0);
    for (int t = 1; t <= 25; t++) begin
      tick(1);
      keys(0, 0, 0, 0, 0);
      checks++;
      if (busy !== (t <= 24)) begin errors++; $display("FAIL jump_busy t=%0d got %0b want %0b", t, busy, t <= 24); end
      if (t == 1 || t == 24) begin
        checks++;
        if (RyuY !== 10'd288) begin errors++; $display("FAIL jump_y t=%0d got %0d want 288", t, RyuY); end
      end
      if (t == 12 || t == 13) begin
        checks++;
        if (RyuY !== 10'd222) begin errors++; $display("FAIL jump_apex t=%0d got %0d want 222", t, RyuY); end
      end
      if (t == 5) begin
        checks += 2;
        if (sprite !== 3'd2) begin errors++; $display("FAIL jump_sprite got %0d want 2", sprite); end
        if (RyuY !== 10'd250) begin errors++; $display("FAIL jump_y5 got %0d want 250", RyuY); end
      end
    end
    checks += 3;
    if (RyuY !== 10'd300) begin errors++; $display("FAIL land_y got %0d want 300", RyuY); end
    if (sprite !== 3'd0) begin errors++; $display("FAIL land_sprite got %0d want 0", sprite); end
    if (RyuX !== 10'd0) begin errors++; $display("FAIL jump_x got %0d want 0", RyuX); end
  endtask

  task automatic test_punch;
    keys(0, 0, 0, 0, 1);
    for (int t = 1; t <= 20; t++) begin
      tick(1);
      checks++;
      if (sprite !== (t <= 8 ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL punch_hold t=%0d got %0d want %0d", t, sprite, t <= 8 ? 1 : 0);
      end
    end
    keys(0, 0, 0, 0, 0);
    tick(1);
    keys(0, 0, 0, 0, 1);
    tick(1);
    checks++;
    if (sprite !== 3'd1) begin errors++; $display("FAIL repunch got %0d want 1", sprite); end
    keys(0, 0, 0, 0, 0);
    tick(8);
  endtask

  task automatic test_reset_mid_jump;
    keys(0, 0, 1, 0, 0);
    tick(1);
    keys(0, 0, 0, 0, 0);
    tick(5);
    checks++;
    if (RyuY !== 10'd243) begin errors++; $display("FAIL jump6_y got %0d want 243", RyuY); end
    @(negedge vga_clk) Reset = 1;
    @(negedge vga_clk) Reset = 0;
    checks += 4;
    if (RyuY !== 10'd300) begin errors++; $display("FAIL rst_jump_y got %0d want 300", RyuY); end
    if (RyuX !== 10'd100) begin errors++; $display("FAIL rst_jump_x got %0d want 100", RyuX); end
    if (sprite !== 3'd0) begin errors++; $display("FAIL rst_jump_sprite got %0d want 0", sprite); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_jump_busy got %0b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_walk;
    test_priority;
    test_clamp;
    test_jump;
    test_punch;
    test_reset_mid_jump;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
